// File: rtl/alu_muldiv_sequencer.sv
// rtl/alu_muldiv_sequencer.sv - multi-cycle unsigned shift-add multiply / restoring divide sequencer
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Ready = (state_q == S_IDLE);
        Done  = (state_q == S_DONE);
    end

    // hi/lo hold {P_hi,P_lo} for multiply and {R,Q} for divide; m is the addend or divisor.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = Operation;
                    cnt_d = CW'(WIDTH - 1);
                    hi_d  = '0;
                    if (Operation[1]) begin
                        m_d  = b;
                        lo_d = a;
                    end else begin
                        m_d  = a;
                        lo_d = b;
                    end
                end
            end
            S_BUSY: begin
                if (op_q[1]) begin
                    if (!div_diff[WIDTH]) begin
                        hi_d = div_diff[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[WIDTH:1];
                    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    // MULHU and REMU take the upper register, MUL and DIVU the lower.
                    result_d = op_q[0] ? hi_d : lo_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign Result = result_q;
endmodule
